// File: rtl/m68k_uart_pkg.sv
// Shared constants and state types for the 68000-bus UART: register map,
// STATUS/CTRL bit positions and the FSM encodings of the bus and bit engines.
package m68k_uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIVL = 2'd2;
  localparam logic [1:0] REG_DIVH = 2'd3;

  // STATUS read bits; CTRL_CLR_ERR is write-only
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_BUSY  = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_FERR     = 3;
  localparam int STAT_RX_IE    = 4;
  localparam int CTRL_CLR_ERR  = 5;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_ACK    = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/m68k_uart_bit_engine.sv
// 8N1 transmit and receive shifters with their bit timers. Each bit latches
// the (clamped) divisor at its start, so divisor writes apply at bit boundaries.
module uart_bit_engine
  import m68k_uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk16,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             tx_start,
  input  logic [7:0]       tx_byte,
  input  logic             rxd,
  output logic             txd,
  output logic             tx_busy,
  output logic             rx_done,
  output logic [7:0]       rx_byte,
  output logic             rx_ferr
);

  logic [DIV_W-1:0] bit_len;
  assign bit_len = (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;

  tx_state_t        tx_state, tx_state_d;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_d, tx_len, tx_len_d;
  logic [7:0]       tx_sh, tx_sh_d;
  logic [2:0]       tx_idx, tx_idx_d;
  logic             txd_d, tx_bit_end;

  assign tx_bit_end = (tx_cnt == tx_len - 1'b1);
  assign tx_busy    = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 1'b1;
    tx_len_d   = tx_len;
    tx_sh_d    = tx_sh;
    tx_idx_d   = tx_idx;
    txd_d      = txd;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_start) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_byte;
          tx_len_d   = bit_len;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_len_d   = bit_len;
          tx_idx_d   = 3'd0;
          txd_d      = tx_sh[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_len_d = bit_len;
          if (tx_idx == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d = tx_idx + 3'd1;
            tx_sh_d  = tx_sh >> 1;
            txd_d    = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_len   <= DIV_W'(2);
      tx_sh    <= '0;
      tx_idx   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_len   <= tx_len_d;
      tx_sh    <= tx_sh_d;
      tx_idx   <= tx_idx_d;
      txd      <= txd_d;
    end
  end

  // rx_s1/rx_s2 synchronise; rx_s3 holds the previous synchronised level for edge detect
  logic             rx_s1, rx_s2, rx_s3;
  rx_state_t        rx_state, rx_state_d;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_d, rx_len, rx_len_d;
  logic [7:0]       rx_sh, rx_sh_d, rx_byte_d;
  logic [2:0]       rx_idx, rx_idx_d;
  logic             rx_done_d, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_len_d   = rx_len;
    rx_sh_d    = rx_sh;
    rx_idx_d   = rx_idx;
    rx_done_d  = 1'b0;
    rx_byte_d  = rx_byte;
    rx_ferr_d  = rx_ferr;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3 && !rx_s2) begin
          rx_state_d = RX_START;
          rx_len_d   = bit_len;
        end
      end
      RX_START: begin
        if (rx_cnt == (rx_len >> 1) - 1'b1) begin
          rx_cnt_d = '0;
          if (rx_s2) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_len_d   = bit_len;
            rx_idx_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_len - 1'b1) begin
          rx_cnt_d = '0;
          rx_len_d = bit_len;
          rx_sh_d  = {rx_s2, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_state_d = RX_STOP;
          else                rx_idx_d   = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == rx_len - 1'b1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_done_d  = 1'b1;
          rx_byte_d  = rx_sh;
          rx_ferr_d  = !rx_s2;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_len   <= DIV_W'(2);
      rx_sh    <= '0;
      rx_idx   <= '0;
      rx_done  <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_len   <= rx_len_d;
      rx_sh    <= rx_sh_d;
      rx_idx   <= rx_idx_d;
      rx_done  <= rx_done_d;
      rx_byte  <= rx_byte_d;
      rx_ferr  <= rx_ferr_d;
    end
  end

endmodule

// File: rtl/m68k_uart.sv
// Memory-mapped UART on the 68000 bus: bus handshake FSM with its own dtack_n,
// DATA/STATUS/DIV registers, RX buffer bookkeeping and the RX interrupt.
module m68k_uart
  import m68k_uart_pkg::*;
#(
  parameter int BAUD_DIV_RESET = 139,
  parameter int DIV_W          = 16
) (
  input  logic       clk16,
  input  logic       reset,
  input  logic       sel_n,
  input  logic       as_n,
  input  logic       lds_n,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       dtack_n,
  input  logic       rxd,
  output logic       txd,
  output logic       irq_n
);

  // Bus handshake: a qualified strobe moves IDLE->ACCESS (the single cycle that
  // carries the register side-effect), then ACK holds dtack_n low until lds_n rises.
  bus_state_t       bus_state, bus_state_d;
  logic [DIV_W-1:0] divisor;
  logic [7:0]       rx_buf, status, rd_mux;
  logic             rx_valid, overrun, ferr, rx_ie;
  logic             access, wr, data_rd, tx_start;
  logic             tx_busy, rx_done, rx_ferr;
  logic [7:0]       rx_byte;

  always_comb begin
    bus_state_d = bus_state;
    case (bus_state)
      BUS_IDLE:   if (!sel_n && !as_n && !lds_n) bus_state_d = BUS_ACCESS;
      BUS_ACCESS: bus_state_d = lds_n ? BUS_IDLE : BUS_ACK;
      BUS_ACK:    if (lds_n) bus_state_d = BUS_IDLE;
      default:    bus_state_d = BUS_IDLE;
    endcase
    if (as_n) bus_state_d = BUS_IDLE;
  end

  assign access   = (bus_state == BUS_ACCESS) && !as_n;
  assign wr       = access && !rw;
  assign data_rd  = access && rw && (addr == REG_DATA);
  assign tx_start = wr && (addr == REG_DATA) && !tx_busy;

  always_comb begin
    status                = 8'h00;
    status[STAT_RX_VALID] = rx_valid;
    status[STAT_TX_BUSY]  = tx_busy;
    status[STAT_OVERRUN]  = overrun;
    status[STAT_FERR]     = ferr;
    status[STAT_RX_IE]    = rx_ie;
    case (addr)
      REG_DATA: rd_mux = rx_buf;
      REG_STAT: rd_mux = status;
      REG_DIVL: rd_mux = divisor[7:0];
      default:  rd_mux = 8'(divisor >> 8);
    endcase
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      bus_state <= BUS_IDLE;
      dtack_n   <= 1'b1;
      data_oe   <= 1'b0;
      data_out  <= 8'h00;
      divisor   <= DIV_W'(BAUD_DIV_RESET);
      rx_buf    <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      ferr      <= 1'b0;
      rx_ie     <= 1'b0;
      irq_n     <= 1'b1;
    end else begin
      bus_state <= bus_state_d;
      dtack_n   <= (bus_state_d != BUS_ACK);
      if (bus_state_d != BUS_ACK)     data_oe <= 1'b0;
      else if (bus_state == BUS_ACCESS) data_oe <= rw;
      if (access) data_out <= rd_mux;

      if (wr && addr == REG_DIVL) divisor[7:0]       <= data_in;
      if (wr && addr == REG_DIVH) divisor[DIV_W-1:8] <= data_in[DIV_W-9:0];
      if (wr && addr == REG_STAT) begin
        rx_ie <= data_in[STAT_RX_IE];
        if (data_in[CTRL_CLR_ERR]) begin
          ferr    <= 1'b0;
          overrun <= 1'b0;
        end
      end

      // A DATA read coinciding with completion returns the old byte and is not an overrun
      if (rx_done) begin
        rx_buf   <= rx_byte;
        rx_valid <= 1'b1;
        if (rx_ferr) ferr <= 1'b1;
        if (rx_valid && !data_rd) overrun <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end

      irq_n <= !(rx_valid && rx_ie);
    end
  end

  uart_bit_engine #(.DIV_W(DIV_W)) u_engine (
    .clk16    (clk16),
    .reset    (reset),
    .divisor  (divisor),
    .tx_start (tx_start),
    .tx_byte  (data_in),
    .rxd      (rxd),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .rx_done  (rx_done),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

endmodule

// File: tb/tb_m68k_uart.sv
// Self-checking bench for m68k_uart: bus handshake, TX frame timing, RX receive,
// overrun, glitch/framing errors, IRQ and reset, against a register-level model.
module tb_m68k_uart;
  import m68k_uart_pkg::*;

  logic       clk16 = 1'b0;
  logic       reset, sel_n, as_n, lds_n, rw, rxd;
  logic [1:0] addr;
  logic [7:0] data_in, data_out;
  logic       data_oe, dtack_n, txd, irq_n;

  int checks   = 0;
  int failures = 0;

  // Reference model: register state as the programmer sees it
  logic [7:0] exp_q[$];
  logic [7:0] m_last;
  logic       m_rx_valid, m_overrun, m_ferr, m_rx_ie;

  m68k_uart #(.BAUD_DIV_RESET(139), .DIV_W(16)) dut (
    .clk16(clk16), .reset(reset), .sel_n(sel_n), .as_n(as_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .dtack_n(dtack_n), .rxd(rxd), .txd(txd), .irq_n(irq_n)
  );

  always #5 clk16 = ~clk16;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    exp_q.delete();
    m_last = 8'h00; m_rx_valid = 0; m_overrun = 0; m_ferr = 0; m_rx_ie = 0;
  endfunction

  function automatic logic [7:0] model_status(input logic busy);
    return {3'b000, m_rx_ie, m_ferr, m_overrun, busy, m_rx_valid};
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop);
    if (m_rx_valid) begin
      m_overrun = 1'b1;
      void'(exp_q.pop_front());
    end
    exp_q.push_back(b);
    m_last = b;
    m_rx_valid = 1'b1;
    if (!stop) m_ferr = 1'b1;
  endfunction

  function automatic logic [7:0] model_data_rd();
    logic [7:0] e;
    e = m_last;
    if (m_rx_valid) begin
      e = exp_q.pop_front();
      m_rx_valid = 1'b0;
    end
    return e;
  endfunction

  function automatic void model_stat_wr(input logic [7:0] d);
    m_rx_ie = d[4];
    if (d[5]) begin
      m_ferr = 1'b0;
      m_overrun = 1'b0;
    end
  endfunction

  // One 68000 byte cycle; also checks dtack latency, release and data_oe direction
  task automatic bus_cycle(input logic is_read, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] q);
    int lat, rel;
    logic oe;
    @(posedge clk16); #1;
    sel_n = 0; as_n = 0; lds_n = 0; rw = is_read; addr = a; data_in = d;
    lat = 0;
    while (dtack_n !== 1'b0 && lat < 20) begin @(posedge clk16); #1; lat++; end
    q = data_out; oe = data_oe;
    lds_n = 1; as_n = 1; sel_n = 1; rw = 1;
    rel = 0;
    while (dtack_n !== 1'b1 && rel < 20) begin @(posedge clk16); #1; rel++; end
    checks++;
    if (lat !== 2 || rel !== 1 || oe !== is_read || data_oe !== 1'b0) begin
      failures++;
      $display("FAIL bus_handshake addr=%0d got lat=%0d rel=%0d oe=%b oe_after=%b need lat=2 rel=1 oe=%b oe_after=0",
               a, lat, rel, oe, data_oe, is_read);
    end
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] q);
    bus_cycle(1'b1, a, 8'h00, q);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus_cycle(1'b0, a, d, q);
  endtask

  task automatic set_div(input int dv);
    logic [15:0] v;
    v = 16'(dv);
    reg_write(REG_DIVL, v[7:0]);
    reg_write(REG_DIVH, v[15:8]);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int dv);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (dv) @(posedge clk16);
      #1;
    end
    rxd = 1'b1;
    repeat (4) @(posedge clk16);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] q;
    reset = 1; sel_n = 1; as_n = 1; lds_n = 1; rw = 1; addr = 0; data_in = 0; rxd = 1;
    repeat (3) @(posedge clk16);
    #1 reset = 0;
    model_reset();
    checks++;
    if ({dtack_n, data_oe, data_out, txd, irq_n} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got dtack_n=%b oe=%b dout=%h txd=%b irq_n=%b need 1 0 00 1 1",
               dtack_n, data_oe, data_out, txd, irq_n);
    end
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin
      failures++; $display("FAIL reset_status got %h need %h", q, model_status(1'b0));
    end
    reg_read(REG_DIVL, q);
    checks++;
    if (q !== 8'd139) begin failures++; $display("FAIL reset_divl got %h need 8b", q); end
    reg_read(REG_DIVH, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL reset_divh got %h need 00", q); end
  endtask

  task automatic test_div_rw();
    logic [7:0] lo, hi;
    int v;
    for (int k = 0; k < 3; k++) begin
      v = $urandom_range(0, 65535);
      set_div(v);
      reg_read(REG_DIVL, lo);
      reg_read(REG_DIVH, hi);
      checks++;
      if ({hi, lo} !== 16'(v)) begin
        failures++; $display("FAIL div_readback got %h need %h", {hi, lo}, 16'(v));
      end
    end
    set_div(139);
  endtask

  // Frame is start(0), 8 data bits LSB first, stop(1), each max(div,2) cycles
  task automatic test_tx(input logic [7:0] b, input int dv, input logic poke);
    int eff, bad, first_bad, waited, lows;
    logic [9:0] frame;
    logic [7:0] q;
    eff = (dv < 2) ? 2 : dv;
    frame = {1'b1, b, 1'b0};
    bad = 0; first_bad = -1; waited = 0; lows = 0;
    set_div(dv);
    fork
      begin
        reg_write(REG_DATA, b);
        if (poke) begin
          repeat (eff * 3) @(posedge clk16);
          reg_read(REG_STAT, q);
          checks++;
          if (q !== model_status(1'b1)) begin
            failures++; $display("FAIL tx_busy_status got %h need %h", q, model_status(1'b1));
          end
          reg_write(REG_DATA, ~b);
        end
      end
      begin
        while (txd !== 1'b0 && waited < 40) begin @(posedge clk16); #1; waited++; end
        for (int i = 0; i < 10 * eff; i++) begin
          if (txd !== frame[i / eff]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
          end
          @(posedge clk16); #1;
        end
      end
    join
    checks++;
    if (waited >= 40 || bad != 0) begin
      failures++;
      $display("FAIL tx_frame byte=%h div=%0d got start_wait=%0d bad_cycles=%0d first_bad=%0d need start and 0 bad",
               b, eff, waited, bad, first_bad);
    end
    for (int i = 0; i < 2 * eff; i++) begin
      if (txd !== 1'b1) lows++;
      @(posedge clk16); #1;
    end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL tx_idle_after got low_cycles=%0d need 0", lows); end
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin
      failures++; $display("FAIL tx_done_status got %h need %h", q, model_status(1'b0));
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] q, e;
    set_div(139);
    send_rx(8'hA3, 1'b1, 139);
    model_rx(8'hA3, 1'b1);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL rx_status got %h need %h", q, model_status(1'b0)); end
    reg_read(REG_DATA, q);
    e = model_data_rd();
    checks++;
    if (q !== e) begin failures++; $display("FAIL rx_data got %h need %h", q, e); end
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL rx_status_cleared got %h need %h", q, model_status(1'b0)); end
  endtask

  task automatic test_rx_random();
    logic [7:0] q, e, b;
    int dv;
    for (int k = 0; k < 4; k++) begin
      dv = $urandom_range(8, 40);
      b = 8'($urandom_range(0, 255));
      set_div(dv);
      send_rx(b, 1'b1, dv);
      model_rx(b, 1'b1);
      reg_read(REG_DATA, q);
      e = model_data_rd();
      checks++;
      if (q !== e) begin failures++; $display("FAIL rx_random div=%0d got %h need %h", dv, q, e); end
    end
    set_div(139);
  endtask

  task automatic test_overrun();
    logic [7:0] q, e;
    send_rx(8'h11, 1'b1, 139); model_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1, 139); model_rx(8'h22, 1'b1);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL overrun_status got %h need %h", q, model_status(1'b0)); end
    reg_read(REG_DATA, q);
    e = model_data_rd();
    checks++;
    if (q !== e) begin failures++; $display("FAIL overrun_data got %h need %h", q, e); end
    reg_write(REG_STAT, 8'h20); model_stat_wr(8'h20);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL overrun_clear got %h need %h", q, model_status(1'b0)); end
  endtask

  task automatic test_glitch_ferr();
    logic [7:0] q, e;
    rxd = 1'b0;
    repeat (40) @(posedge clk16);
    #1 rxd = 1'b1;
    repeat (200) @(posedge clk16);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL glitch_status got %h need %h", q, model_status(1'b0)); end
    send_rx(8'h7E, 1'b0, 139); model_rx(8'h7E, 1'b0);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL ferr_status got %h need %h", q, model_status(1'b0)); end
    reg_read(REG_DATA, q);
    e = model_data_rd();
    checks++;
    if (q !== e) begin failures++; $display("FAIL ferr_data got %h need %h", q, e); end
    reg_write(REG_STAT, 8'h20); model_stat_wr(8'h20);
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL ferr_clear got %h need %h", q, model_status(1'b0)); end
  endtask

  task automatic test_irq();
    logic [7:0] q, e, b;
    b = 8'($urandom_range(0, 255));
    reg_write(REG_STAT, 8'h10); model_stat_wr(8'h10);
    checks++;
    if (irq_n !== 1'b1) begin failures++; $display("FAIL irq_idle got %b need 1", irq_n); end
    set_div(16);
    send_rx(b, 1'b1, 16); model_rx(b, 1'b1);
    checks++;
    if (irq_n !== 1'b0) begin failures++; $display("FAIL irq_assert got %b need 0", irq_n); end
    reg_read(REG_DATA, q);
    e = model_data_rd();
    checks++;
    if (q !== e) begin failures++; $display("FAIL irq_data got %h need %h", q, e); end
    repeat (3) @(posedge clk16);
    #1;
    checks++;
    if (irq_n !== 1'b1) begin failures++; $display("FAIL irq_release got %b need 1", irq_n); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] q;
    set_div(20);
    reg_write(REG_DATA, 8'hC3);
    repeat (2) @(posedge clk16);
    #1;
    checks++;
    if (txd !== 1'b0) begin failures++; $display("FAIL mid_tx_start got txd=%b need 0", txd); end
    reset = 1'b1;
    @(posedge clk16); #1;
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got %b need 1", txd); end
    reset = 1'b0;
    model_reset();
    reg_read(REG_DIVL, q);
    checks++;
    if (q !== 8'd139) begin failures++; $display("FAIL reset_mid_divl got %h need 8b", q); end
    reg_read(REG_STAT, q);
    checks++;
    if (q !== model_status(1'b0)) begin failures++; $display("FAIL reset_mid_status got %h need %h", q, model_status(1'b0)); end
  endtask

  initial begin
    test_reset();
    test_div_rw();
    test_tx(8'h55, 139, 1'b1);
    test_tx(8'($urandom_range(0, 255)), $urandom_range(3, 12), 1'b0);
    test_tx(8'($urandom_range(0, 255)), 1, 1'b0);
    test_tx(8'($urandom_range(0, 255)), 0, 1'b0);
    test_rx_basic();
    test_rx_random();
    test_overrun();
    test_glitch_ferr();
    test_irq();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
